// File: rtl/tt_check_pkg.sv
// ---------------------------------------------------------------------------
// tt_check_pkg
//   Shared types and helpers for the truth-table response checker.
//   - tt_state_e : checker state (IDLE, RUN, DONE)
//   - DEPTH      : truth-table depth for the default 4-input configuration
//   - ALL_COV    : coverage value meaning "every vector has been sampled"
//   - sat_inc    : saturating increment used by the mismatch counter
// ---------------------------------------------------------------------------
package tt_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tt_state_e;

  // Defaults for the standard 4-input exercise block. The checker derives its
  // own depth from its N_IN parameter; these document the common case.
  localparam int          DEF_N_IN = 4;
  localparam int          DEPTH    = 2 ** DEF_N_IN;
  localparam logic [DEPTH-1:0] ALL_COV = {DEPTH{1'b1}};

  // Increment val by one unless it already sits at max_val.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/tt_response_checker_timeout_cnt.sv
// ---------------------------------------------------------------------------
// tt_timeout_cnt
//   Idle-cycle counter for the response checker. Counts cycles spent in RUN
//   without a sample and flags when the allowed budget is used up.
//   Ports:
//     clk    in   system clock
//     rst_n  in   synchronous active-low reset
//     clear  in   return the count to zero (takes priority over incr)
//     incr   in   advance the count by one
//     count  out  current count, width $clog2(TIMEOUT)
//     tc     out  terminal count: count == TIMEOUT-1
// ---------------------------------------------------------------------------
module tt_timeout_cnt #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             incr,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr && (count != TC_VAL)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/tt_response_checker.sv
// ---------------------------------------------------------------------------
// tt_response_checker
//   Receiving end of an exhaustive truth-table stimulus run. For every vector
//   strobed in with vec_valid it records the DUT output, marks the vector as
//   covered, and compares against the expected truth table. The run ends in
//   DONE once all 2^N_IN vectors have been seen, or when the stimulus goes
//   quiet for TIMEOUT cycles.
//   Ports:
//     clk             in   system clock, rising edge
//     rst_n           in   synchronous active-low reset
//     start           in   one-cycle pulse: clear results, enter RUN
//     vec_valid       in   vec_idx / f_in valid this cycle
//     vec_idx         in   applied input vector, A is the MSB
//     f_in            in   settled DUT output for vec_idx
//     busy            out  state is RUN
//     done            out  state is DONE
//     pass            out  done, no timeout, no mismatches
//     timeout         out  run aborted by idle timeout
//     err_count       out  mismatching samples, saturating
//     first_fail_vld  out  at least one mismatch recorded
//     first_fail_idx  out  vec_idx of the first mismatch
//     coverage        out  bit k set once vector k has been sampled
//     captured        out  last sampled f for each vector
// ---------------------------------------------------------------------------
module tt_response_checker
  import tt_check_pkg::*;
#(
  parameter int                   N_IN     = 4,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = 16'hA5C3,
  parameter int                   ERR_W    = 5,
  parameter int                   TIMEOUT  = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   vec_valid,
  input  logic [N_IN-1:0]        vec_idx,
  input  logic                   f_in,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [ERR_W-1:0]       err_count,
  output logic                   first_fail_vld,
  output logic [N_IN-1:0]        first_fail_idx,
  output logic [(1<<N_IN)-1:0]   coverage,
  output logic [(1<<N_IN)-1:0]   captured
);

  localparam int                  TBL_DEPTH = 1 << N_IN;
  localparam logic [TBL_DEPTH-1:0] COV_FULL = {TBL_DEPTH{1'b1}};
  localparam logic [31:0]         ERR_MAX   = (32'd1 << ERR_W) - 32'd1;
  localparam int                  CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  tt_state_e state, state_n;

  logic                 busy_n, done_n, pass_n, timeout_n;
  logic [ERR_W-1:0]     err_n;
  logic                 ffv_n;
  logic [N_IN-1:0]      ffi_n;
  logic [TBL_DEPTH-1:0] cov_n, cap_n;

  logic                 cnt_clr, cnt_inc, cnt_tc;
  logic [CNT_W-1:0]     cnt_val;

  tt_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clr),
    .incr  (cnt_inc),
    .count (cnt_val),
    .tc    (cnt_tc)
  );

  // Next-state and next-result logic. Every output flop is loaded from a
  // value computed here, so all outputs come straight off registers.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    state_n   = state;
    timeout_n = timeout;
    err_n     = err_count;
    ffv_n     = first_fail_vld;
    ffi_n     = first_fail_idx;
    cov_n     = coverage;
    cap_n     = captured;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;

    if (start) begin
      // Restart from any state; a same-cycle sample is dropped.
      state_n   = RUN;
      timeout_n = 1'b0;
      err_n     = '0;
      ffv_n     = 1'b0;
      ffi_n     = '0;
      cov_n     = '0;
      cap_n     = '0;
      cnt_clr   = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (vec_valid) begin
            cap_n[vec_idx] = f_in;
            cov_n[vec_idx] = 1'b1;
            if (f_in != EXPECTED[vec_idx]) begin
              err_n = ERR_W'(sat_inc(32'(err_count), ERR_MAX));
              if (!first_fail_vld) begin
                ffv_n = 1'b1;
                ffi_n = vec_idx;
              end
            end
            cnt_clr = 1'b1;
            // Completion looks at coverage including this sample.
            if (cov_n == COV_FULL) begin
              state_n = DONE;
            end
          end else if (cnt_tc) begin
            state_n   = DONE;
            timeout_n = 1'b1;
            cnt_clr   = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        IDLE:    cnt_clr = 1'b1;
        DONE:    cnt_clr = 1'b1;
        default: begin
          state_n = IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end

    busy_n = (state_n == RUN);
    done_n = (state_n == DONE);
    pass_n = done_n && !timeout_n && (err_n == '0);
  end

  // NOTE: coverage and captured are plain flop vectors, not RAM, and must read
  // as zero out of reset, so they sit in the reset branch with the rest.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
      coverage       <= '0;
      captured       <= '0;
    end else begin
      state          <= state_n;
      busy           <= busy_n;
      done           <= done_n;
      pass           <= pass_n;
      timeout        <= timeout_n;
      err_count      <= err_n;
      first_fail_vld <= ffv_n;
      first_fail_idx <= ffi_n;
      coverage       <= cov_n;
      captured       <= cap_n;
    end
  end

  // The counter value itself is only needed through tc.
  logic unused_cnt;
  assign unused_cnt = ^cnt_val;

endmodule
